// File: rtl/maze_pkg.sv
// maze_pkg: shared types and constants for the maze tile memory and the
// clients that read it through maze_port_arbiter.
//
// Contents:
//   tile_t        2-bit tile code stored per maze cell
//   MAZE_*        tile grid geometry and address width
//   NUM_REQ       number of tile-port requesters (Pac-Man + four ghosts)
//   REQ_*         requester indices
//   idx_width()   index width for an N-entry one-hot vector
package maze_pkg;

   typedef enum logic [1:0] {
      TILE_EMPTY = 2'd0,
      TILE_WALL  = 2'd1,
      TILE_FOOD  = 2'd2,
      TILE_POWER = 2'd3
   } tile_t;

   localparam int unsigned MAZE_ADDR_W = 13;
   localparam int unsigned MAZE_COLS   = 80;
   localparam int unsigned MAZE_ROWS   = 60;
   localparam int unsigned NUM_REQ     = 5;

   localparam int unsigned REQ_PAC    = 0;
   localparam int unsigned REQ_GHOST0 = 1;
   localparam int unsigned REQ_GHOST1 = 2;
   localparam int unsigned REQ_GHOST2 = 3;
   localparam int unsigned REQ_GHOST3 = 4;

   // Width of an index into an n-entry vector; never less than 1 bit.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/maze_rr_pick.sv
// maze_rr_pick: combinational round-robin selector.
// Scans req starting at position ptr and wrapping modulo NUM_REQ; the first
// set bit found is returned as a one-hot pick.
//
// Ports:
//   req    in   NUM_REQ  eligible request vector (already masked by caller)
//   ptr    in   PTR_W    position where the search starts (0..NUM_REQ-1)
//   pick   out  NUM_REQ  one-hot winner, all-zero when nothing is eligible
//   found  out  1        high when pick is non-zero
module maze_rr_pick #(
   parameter int unsigned NUM_REQ = maze_pkg::NUM_REQ,
   parameter int unsigned PTR_W   = maze_pkg::idx_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] pick,
   output logic               found
);

   // One extra bit so ptr + k cannot overflow before the wrap subtraction.
   logic [PTR_W:0]   sum;
   logic [PTR_W-1:0] idx;

   always_comb begin
      pick  = '0;
      found = 1'b0;
      sum   = '0;
      idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         sum = {1'b0, ptr} + (PTR_W+1)'(k);
         if (sum >= (PTR_W+1)'(NUM_REQ)) begin
            sum = sum - (PTR_W+1)'(NUM_REQ);
         end
         idx = sum[PTR_W-1:0];
         if (!found && req[idx]) begin
            pick[idx] = 1'b1;
            found     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/maze_port_arbiter.sv
// maze_port_arbiter: shares the single synchronous-read port of the maze tile
// RAM between Pac-Man movement (requester 0) and the four ghosts (1..4).
// One grant per cycle at most; each grant issues a RAM read whose data comes
// back to the granted requester as a one-cycle rsp_valid strobe exactly
// MEM_LAT+1 cycles after its gnt pulse. Responses are never reordered.
//
// Build option: define MAZE_ARB_PAC_PRIORITY_EN to make requester 0 win
// whenever it is eligible; ghosts then rotate among themselves and the
// round-robin pointer only moves on ghost grants. Undefined: plain
// round-robin over all requesters.
//
// Ports:
//   board_clk  in   1               system clock
//   Reset      in   1               asynchronous, active-high reset
//   stall      in   1               suppress new grants; in-flight reads finish
//   req        in   NUM_REQ         per-requester request level
//   req_addr   in   NUM_REQ*ADDR_W  flattened addresses, slice i = [i*ADDR_W +: ADDR_W]
//   gnt        out  NUM_REQ         one-hot grant pulse
//   mem_en     out  1               tile RAM read enable
//   mem_addr   out  ADDR_W          tile RAM address (holds when idle)
//   mem_rdata  in   DATA_W          tile RAM data, valid MEM_LAT cycles after mem_en
//   rsp_valid  out  NUM_REQ         one-hot response strobe
//   rsp_data   out  DATA_W          tile code, qualified by rsp_valid
//   busy       out  1               any read in flight
//   gnt_cnt    out  16              wrapping count of grants issued
module maze_port_arbiter #(
   parameter int unsigned NUM_REQ = maze_pkg::NUM_REQ,
   parameter int unsigned ADDR_W  = maze_pkg::MAZE_ADDR_W,
   parameter int unsigned DATA_W  = 2,
   parameter int unsigned MEM_LAT = 1
) (
   input  logic                      board_clk,
   input  logic                      Reset,
   input  logic                      stall,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   output logic [NUM_REQ-1:0]        gnt,
   output logic                      mem_en,
   output logic [ADDR_W-1:0]         mem_addr,
   input  logic [DATA_W-1:0]         mem_rdata,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic [DATA_W-1:0]         rsp_data,
   output logic                      busy,
   output logic [15:0]               gnt_cnt
);

   import maze_pkg::*;

   localparam int unsigned PTR_W = idx_width(NUM_REQ);

   logic [NUM_REQ-1:0] gnt_q;
   logic               mem_en_q;
   logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
   logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
   logic [15:0]        gnt_cnt_q;
   logic [PTR_W-1:0]   ptr_q, ptr_d;

   // Read pipeline: stage 0 lines up with the gnt cycle, stage MEM_LAT with
   // the cycle in which mem_rdata is valid for that grant.
   logic [MEM_LAT:0]   pipe_vld_q;
   logic [PTR_W-1:0]   pipe_idx_q [MEM_LAT+1];

   logic [NUM_REQ-1:0] elig;
   logic [NUM_REQ-1:0] pick;
   logic               found;
   logic               ptr_adv;
   logic [PTR_W-1:0]   pick_idx;

   // The requester granted this cycle still holds req until it sees gnt, so it
   // is masked out of the decision at the next edge.
   assign elig = stall ? '0 : (req & ~gnt_q);

`ifdef MAZE_ARB_PAC_PRIORITY_EN
   logic [NUM_REQ-1:0] pac_mask;
   logic [NUM_REQ-1:0] pac_pick, ghost_pick;
   logic               pac_found, ghost_found;

   always_comb begin
      pac_mask          = '0;
      pac_mask[REQ_PAC] = 1'b1;
   end

   maze_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_pick_pac (
      .req   (elig & pac_mask),
      .ptr   ('0),
      .pick  (pac_pick),
      .found (pac_found)
   );

   maze_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_pick_ghost (
      .req   (elig & ~pac_mask),
      .ptr   (ptr_q),
      .pick  (ghost_pick),
      .found (ghost_found)
   );

   assign pick    = pac_found ? pac_pick : ghost_pick;
   assign found   = pac_found | ghost_found;
   assign ptr_adv = !pac_found && ghost_found;
`else
   maze_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_pick (
      .req   (elig),
      .ptr   (ptr_q),
      .pick  (pick),
      .found (found)
   );

   assign ptr_adv = found;
`endif

   // Encode the winner and select its address; idle keeps the last address.
   always_comb begin
      pick_idx   = '0;
      mem_addr_d = mem_addr_q;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pick[i]) begin
            pick_idx   = PTR_W'(i);
            mem_addr_d = req_addr[i*ADDR_W +: ADDR_W];
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (ptr_adv) begin
         ptr_d = (pick_idx == PTR_W'(NUM_REQ - 1)) ? '0 : pick_idx + PTR_W'(1);
      end
   end

   always_comb begin
      rsp_valid_d = '0;
      rsp_data_d  = rsp_data_q;
      if (pipe_vld_q[MEM_LAT]) begin
         rsp_valid_d[pipe_idx_q[MEM_LAT]] = 1'b1;
         rsp_data_d                       = mem_rdata;
      end
   end

   always_ff @(posedge board_clk or posedge Reset) begin
      if (Reset) begin
         gnt_q       <= '0;
         mem_en_q    <= 1'b0;
         mem_addr_q  <= '0;
         gnt_cnt_q   <= '0;
         ptr_q       <= '0;
         rsp_valid_q <= '0;
         rsp_data_q  <= '0;
      end else begin
         gnt_q       <= pick;
         mem_en_q    <= found;
         mem_addr_q  <= mem_addr_d;
         gnt_cnt_q   <= gnt_cnt_q + 16'(found);
         ptr_q       <= ptr_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

   always_ff @(posedge board_clk or posedge Reset) begin
      if (Reset) begin
         pipe_vld_q <= '0;
         for (int s = 0; s <= MEM_LAT; s++) begin
            pipe_idx_q[s] <= '0;
         end
      end else begin
         pipe_vld_q    <= {pipe_vld_q[MEM_LAT-1:0], found};
         pipe_idx_q[0] <= pick_idx;
         for (int s = 1; s <= MEM_LAT; s++) begin
            pipe_idx_q[s] <= pipe_idx_q[s-1];
         end
      end
   end

   assign gnt       = gnt_q;
   assign mem_en    = mem_en_q;
   assign mem_addr  = mem_addr_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign busy      = |pipe_vld_q;
   assign gnt_cnt   = gnt_cnt_q;

endmodule
